// File: rtl/multi_digit_counter_pkg.sv
// Shared definitions for the multi-digit BCD counter: seven-segment
// patterns (active-low, bit6..bit0 = middle..top), count direction and
// BCD helpers used by the counter core and the per-digit decoder.
package multi_digit_counter_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  // Active-low segment patterns, bit order 0=top .. 6=middle.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Count direction as carried on the 'down' input.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  // A non-decimal nibble loads as zero for that digit only.
  function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MIN : nib;
  endfunction

endpackage

// File: rtl/multi_digit_counter_seg7_decode.sv
// Single-digit BCD to active-low seven-segment decoder. Purely
// combinational; codes above 9 blank the digit.
module seg7_decode
  import multi_digit_counter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  // Look up the segment pattern for the incoming BCD code.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so
    // no path can leave it unassigned and infer a latch.
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_counter.sv
// Cascaded decimal up/down counter driven by a debounced push-button.
// The button is synchronized, debounced, and each debounced release
// produces one step; 'set' loads a BCD value and wins over a step.
module multi_digit_counter
  import multi_digit_counter_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        button,
  input  logic                        down,
  input  logic                        set,
  input  logic [BCD_W*NUM_DIGITS-1:0] input_value,
  output logic [BCD_W*NUM_DIGITS-1:0] output_value,
  output logic [SEG_W*NUM_DIGITS-1:0] displayed_value,
  output logic                        overflow
);

  localparam int VAL_W = BCD_W * NUM_DIGITS;
  // The counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_level_q, db_level_d;
  logic             db_prev_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             step_evt;
  logic [VAL_W-1:0] value_q, value_d;
  logic             overflow_q, overflow_d;
  logic             carry;
  logic [BCD_W-1:0] digit;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q,
      // giving two real flop stages rather than one collapsed wire.
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and the delayed level used for release detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // One-cycle step on a debounced release (1 -> 0).
  assign step_evt = db_prev_q & ~db_level_q;

  // Digit chain: load wins over step; a step ripples carry/borrow through
  // all digits in the same cycle and the final carry marks a wrap.
  always_comb begin
    value_d    = value_q;
    overflow_d = 1'b0;
    carry      = 1'b0;
    digit      = '0;
    if (set) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        value_d[BCD_W*i +: BCD_W] = bcd_sanitize(input_value[BCD_W*i +: BCD_W]);
      end
    end else if (step_evt) begin
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit = value_q[BCD_W*i +: BCD_W];
        if (carry) begin
          if (dir_e'(down) == DIR_DOWN) begin
            if (digit == BCD_MIN) begin
              digit = BCD_MAX;
            end else begin
              digit = digit - 1'b1;
              carry = 1'b0;
            end
          end else begin
            if (digit >= BCD_MAX) begin
              digit = BCD_MIN;
            end else begin
              digit = digit + 1'b1;
              carry = 1'b0;
            end
          end
        end
        value_d[BCD_W*i +: BCD_W] = digit;
      end
      overflow_d = carry;
    end
  end

  // Count register and the single-cycle wrap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      overflow_q <= overflow_d;
    end
  end

  assign output_value = value_q;
  assign overflow     = overflow_q;

  // One decoder per digit; the display follows the registered count.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    seg7_decode u_seg7_decode (
      .bcd_i (value_q[BCD_W*g +: BCD_W]),
      .seg_o (displayed_value[SEG_W*g +: SEG_W])
    );
  end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Self-checking bench for multi_digit_counter with four digits and a
// four-cycle debounce. Expected results are queued when stimulus is
// applied and compared once the counter has had time to respond.
module tb_multi_digit_counter;

  localparam int ND = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset, button, down, set;
  logic [15:0]   input_value;
  logic [15:0]   output_value;
  logic [27:0]   displayed_value;
  logic          overflow;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    string       name;
    logic [15:0] value;
    int          ovf_cycles;
    int          steps;
    int          latency;
  } exp_t;

  exp_t sb[$];

  multi_digit_counter #(
    .NUM_DIGITS      (ND),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .button          (button),
    .down            (down),
    .set             (set),
    .input_value     (input_value),
    .output_value    (output_value),
    .displayed_value (displayed_value),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1);
  end

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference segment table, written independently of the design.
  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] segs_of(input logic [15:0] v);
    logic [27:0] r;
    for (int d = 0; d < ND; d++) r[7*d +: 7] = seg_ref(v[4*d +: 4]);
    return r;
  endfunction

  // Press, release (optionally with bounces) and watch the outputs.
  task automatic press_release(input int hold, input bit bounce, input int budget,
                               output int latency, output int ovf_cycles, output int changes);
    logic [15:0] prev;
    button = 1'b1;
    repeat (hold) tick();
    button = 1'b0;
    if (bounce) begin
      tick(); button = 1'b1;
      tick(); button = 1'b0;
      tick(); button = 1'b1;
      tick(); button = 1'b0;
    end
    latency    = -1;
    ovf_cycles = 0;
    changes    = 0;
    prev       = output_value;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (overflow === 1'b1) ovf_cycles++;
      if (output_value !== prev) begin
        changes++;
        if (latency < 0) latency = i;
        prev = output_value;
      end
    end
  endtask

  task automatic load(input logic [15:0] v);
    set         = 1'b1;
    input_value = v;
    tick();
    set         = 1'b0;
  endtask

  // Run one release and compare against the oldest queued expectation.
  task automatic step_and_compare(input bit check_latency);
    int   lat, ovf, ch;
    exp_t e;
    press_release(10, 1'b0, 20, lat, ovf, ch);
    e = sb.pop_front();
    n_compared++;
    if (output_value !== e.value) begin
      n_mismatched++;
      $display("FAIL %s value: got %h want %h", e.name, output_value, e.value);
    end
    n_compared++;
    if (ovf !== e.ovf_cycles) begin
      n_mismatched++;
      $display("FAIL %s overflow_cycles: got %0d want %0d", e.name, ovf, e.ovf_cycles);
    end
    n_compared++;
    if (ch !== e.steps) begin
      n_mismatched++;
      $display("FAIL %s steps: got %0d want %0d", e.name, ch, e.steps);
    end
    if (check_latency) begin
      n_compared++;
      if (lat !== e.latency) begin
        n_mismatched++;
        $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.latency);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; button = 1'b0; down = 1'b0; set = 1'b0; input_value = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_compared++;
    if (output_value !== 16'h0000) begin
      n_mismatched++;
      $display("FAIL reset_value: got %h want 0000", output_value);
    end
    n_compared++;
    if (overflow !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    n_compared++;
    if (displayed_value !== {4{7'b1000000}}) begin
      n_mismatched++;
      $display("FAIL reset_display: got %b want %b", displayed_value, {4{7'b1000000}});
    end
  endtask

  task automatic test_single_step();
    sb.push_back('{name: "single_step", value: 16'h0001, ovf_cycles: 0, steps: 1, latency: 7});
    step_and_compare(1'b1);
  endtask

  task automatic test_carry();
    load(16'h0999);
    n_compared++;
    if (output_value !== 16'h0999) begin
      n_mismatched++;
      $display("FAIL load_0999: got %h want 0999", output_value);
    end
    sb.push_back('{name: "carry_up", value: 16'h1000, ovf_cycles: 0, steps: 1, latency: 7});
    step_and_compare(1'b1);
    load(16'h9999);
    sb.push_back('{name: "wrap_up", value: 16'h0000, ovf_cycles: 1, steps: 1, latency: 7});
    step_and_compare(1'b0);
  endtask

  task automatic test_borrow();
    load(16'h0000);
    down = 1'b1;
    sb.push_back('{name: "wrap_down", value: 16'h9999, ovf_cycles: 1, steps: 1, latency: 7});
    step_and_compare(1'b1);
    load(16'h1000);
    sb.push_back('{name: "borrow_down", value: 16'h0999, ovf_cycles: 0, steps: 1, latency: 7});
    step_and_compare(1'b0);
    down = 1'b0;
  endtask

  task automatic test_glitch();
    int   lat, ovf, ch;
    exp_t e;
    logic [15:0] prev;
    // Current count is 0999; a 3-cycle glitch must not reach the debouncer output.
    sb.push_back('{name: "glitch", value: 16'h0999, ovf_cycles: 0, steps: 0, latency: -1});
    button = 1'b1;
    repeat (3) tick();
    button = 1'b0;
    ch   = 0;
    prev = output_value;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (output_value !== prev) begin
        ch++;
        prev = output_value;
      end
    end
    e = sb.pop_front();
    n_compared++;
    if (output_value !== e.value || ch !== e.steps) begin
      n_mismatched++;
      $display("FAIL %s: got value %h steps %0d want value %h steps %0d",
               e.name, output_value, ch, e.value, e.steps);
    end
    sb.push_back('{name: "bounce", value: 16'h1000, ovf_cycles: 0, steps: 1, latency: -1});
    press_release(10, 1'b1, 25, lat, ovf, ch);
    e = sb.pop_front();
    n_compared++;
    if (output_value !== e.value || ch !== e.steps || ovf !== e.ovf_cycles) begin
      n_mismatched++;
      $display("FAIL %s: got value %h steps %0d ovf %0d want value %h steps %0d ovf %0d",
               e.name, output_value, ch, ovf, e.value, e.steps, e.ovf_cycles);
    end
  endtask

  task automatic test_set_collision();
    exp_t e;
    // Count is 1000. Release, then assert set exactly in the step-event cycle.
    button = 1'b1;
    repeat (10) tick();
    button = 1'b0;
    repeat (6) tick();
    n_compared++;
    if (output_value !== 16'h1000) begin
      n_mismatched++;
      $display("FAIL collide_pre: got %h want 1000", output_value);
    end
    sb.push_back('{name: "set_collide", value: 16'h4205, ovf_cycles: 0, steps: 0, latency: -1});
    set = 1'b1;
    input_value = 16'h42A5;
    tick();
    set = 1'b0;
    e = sb.pop_front();
    n_compared++;
    if (output_value !== e.value) begin
      n_mismatched++;
      $display("FAIL %s load: got %h want %h", e.name, output_value, e.value);
    end
    repeat (5) tick();
    n_compared++;
    if (output_value !== e.value) begin
      n_mismatched++;
      $display("FAIL %s deferred_step: got %h want %h", e.name, output_value, e.value);
    end
  endtask

  task automatic test_reset_mid();
    int   ch, ovf;
    logic [15:0] prev;
    button = 1'b1;
    repeat (10) tick();
    button = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_compared++;
    if (output_value !== 16'h0000) begin
      n_mismatched++;
      $display("FAIL reset_mid_value: got %h want 0000", output_value);
    end
    ch = 0; ovf = 0; prev = output_value;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (overflow === 1'b1) ovf++;
      if (output_value !== prev) begin
        ch++;
        prev = output_value;
      end
    end
    n_compared++;
    if (ch !== 0 || ovf !== 0) begin
      n_mismatched++;
      $display("FAIL reset_mid_nostep: got steps %0d ovf %0d want 0 0", ch, ovf);
    end
    n_compared++;
    if (displayed_value !== {4{7'b1000000}}) begin
      n_mismatched++;
      $display("FAIL reset_mid_display: got %b want %b", displayed_value, {4{7'b1000000}});
    end
  endtask

  task automatic test_display();
    logic [15:0] pats [3];
    pats[0] = 16'h3210;
    pats[1] = 16'h7654;
    pats[2] = 16'h9898;
    for (int p = 0; p < 3; p++) begin
      load(pats[p]);
      n_compared++;
      if (displayed_value !== segs_of(pats[p])) begin
        n_mismatched++;
        $display("FAIL display_%h: got %b want %b", pats[p], displayed_value, segs_of(pats[p]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_carry();
    test_borrow();
    test_glitch();
    test_set_collision();
    test_reset_mid();
    test_display();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4, number of cascaded decimal digits (1..8).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 16, consecutive stable clk cycles required to accept a button level change (>=2).
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port button  input  1  raw asynchronous push-button, high = pressed.
REQ-006 SHALL provide port down  input  1  count direction: 0 = increment, 1 = decrement.
REQ-007 SHALL provide port set  input  1  level load request.
REQ-008 SHALL provide port input_value  input  4*NUM_DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-009 SHALL provide port output_value  output  4*NUM_DIGITS  registered BCD count, digit 0 in bits [3:0].
REQ-010 SHALL provide port displayed_value  output  7*NUM_DIGITS  active-low segments per digit, bit order 0=top,1=upper-right,2=lower-right,3=bottom,4=lower-left,5=upper-left,6=middle.
REQ-011 SHALL provide port overflow  output  1  single-cycle pulse on wrap-around.

Function
REQ-012 button SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Debounced level SHALL change only after synchronized button differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate match restarts the count.
REQ-014 A step event SHALL be a debounced 1->0 transition (release), one cycle wide.
REQ-015 Priority per cycle SHALL be reset > set > step; a step coinciding with set SHALL be discarded, not deferred.
REQ-016 While set is high, output_value SHALL load input_value every cycle; a nibble >9 SHALL load as 0 for that digit only.
REQ-017 Up step: digit 0 +1; a digit at 9 SHALL become 0 and carry into the next digit, same cycle.
REQ-018 Down step: digit 0 -1; a digit at 0 SHALL become 9 and borrow from the next digit, same cycle.
REQ-019 Up from all-9s SHALL give all-0s; down from all-0s SHALL give all-9s; either SHALL assert overflow for exactly one cycle.
REQ-020 down SHALL be sampled in the cycle the step event is applied.
REQ-021 output_value SHALL update on the clk edge following the step-event cycle; total raw-release-to-update latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-022 displayed_value SHALL be combinational from output_value: 0=1000000,1=1111001,2=0100100,3=0110000,4=0011001,5=0010010,6=0000010,7=1111000,8=0000000,9=0010000 (bit6..bit0); any other code SHALL display 1111111.
REQ-023 Debouncer SHALL keep running while set is high.

Reset
REQ-024 reset SHALL clear output_value to 0, overflow to 0, synchronizer flops, debounced level and debounce counter to 0; displayed_value SHALL therefore read 1000000 per digit.
REQ-025 Reset mid-debounce SHALL discard the pending edge; no step event SHALL follow reset release unless a fresh full debounce completes.

Structure
REQ-026 A shared package SHALL hold the 7-segment pattern constants and the blank pattern.
REQ-027 Per-digit BCD-to-segment decode SHALL be sub-module seg7_decode, instantiated NUM_DIGITS times via generate.
REQ-028 Synchronizer, debouncer and digit chain SHALL remain inside multi_digit_counter.

Verification (NUM_DIGITS=4, DEBOUNCE_CYCLES=4)
REQ-029 Press/release held 10 cycles each from 0000, down=0 -> output_value 0001 exactly 7 cycles after release edge; overflow stays 0.
REQ-030 set with input_value 0999, then one release, down=0 -> 1000; from 9999 -> 0000 with one-cycle overflow.
REQ-031 From 0000, down=1, one release -> 9999 with overflow pulse; from 1000 -> 0999, no overflow.
REQ-032 Button glitch high for 3 cycles -> no step, output unchanged; 1-cycle bounces during release -> exactly one step.
REQ-033 set asserted in step-event cycle with input_value 42A5 -> 4205 loaded, no extra increment.
REQ-034 reset asserted 2 cycles after release, deasserted -> 0000, no step follows, displayed_value all 1000000.
